bp_update_ctrl: RTL and testbench
=================================

// Module: bp_update_ctrl
// PURPOSE
//  Update/recovery controller for the gshare predictor. Runs a counter-table init sweep after reset.
//  Holds one queue entry per in-flight predicted branch: PC, pred_index, predicted direction.
//  Matches each EX resolution against the oldest entry, drives one registered table-update
//  write per cycle, and flags mispredicts. On a mispredict it flushes younger entries.
// PARAMETERS
//  CTableSize  256  counter-table entries; IdxW = $clog2(CTableSize)
//  QDepth      4    in-flight prediction queue depth (power of 2, >=2)
//  CounterLen  2    counter width; init value is '0 (weakly taken under MSB-inverted read)
// PORTS
//  clk_i            in   1     clock
//  rst_ni           in   1     reset, asynchronous, active-low
//  pred_valid_i     in   1     fetch issued a conditional-branch prediction this cycle
//  pred_ready_o     out  1     queue can accept (not full, state RUN, no flush pending)
//  pred_pc_i        in   32    PC of predicted branch
//  pred_index_i     in   IdxW  gshare index used for the prediction
//  pred_taken_i     in   1     predicted direction
//  ex_br_valid_i    in   1     EX resolved a conditional branch
//  ex_br_pc_i       in   32    resolved branch PC
//  ex_br_taken_i    in   1     actual direction
//  upd_valid_o      out  1     write ctable entry this cycle
//  upd_index_o      out  IdxW  entry to write
//  upd_init_o       out  1     1: write init value (sweep); 0: inc/dec per upd_taken_o
//  upd_taken_o      out  1     train direction
//  mispredict_o     out  1     1-cycle pulse: direction or PC mismatch at queue head
//  orphan_o         out  1     1-cycle pulse: EX resolution while queue empty
//  init_busy_o      out  1     init sweep in progress
// BEHAVIOUR
//  Reset (async assert): state=INIT, sweep ptr=0, queue empty, all outputs 0 except init_busy_o=1.
//  States:
//  - INIT: each cycle upd_valid_o=1, upd_init_o=1, upd_index_o=ptr; ptr++.
//    After ptr==CTableSize-1 is written, go to RUN (CTableSize cycles total).
//    In INIT: pred_ready_o=0; ex_br_valid_i is ignored (no orphan_o).
//  - RUN: normal operation, rules below.
//  - FLUSH: entered for exactly one cycle after a mispredict. Queue cleared (rd=wr, count=0).
//    pred_ready_o=0 and no push. ex_br_valid_i in FLUSH pulses orphan_o. Returns to RUN.
//  Push: pred_valid_i & pred_ready_o writes {pc,index,taken} at wr ptr.
//    pred_ready_o = (state==RUN) & (count<QDepth) & ~mispredict_o. Combinational.
//    No push at full, even with a same-cycle pop.
//    pred_valid_i & ~pred_ready_o: dropped, no side effect.
//  Resolve (RUN, ex_br_valid_i):
//  - queue empty: orphan_o=1 next cycle, no update, no pop.
//  - else pop head. Registered outputs next cycle:
//    upd_valid_o=1, upd_init_o=0, upd_index_o=head.index, upd_taken_o=ex_br_taken_i.
//  - mispredict_o=1 next cycle if head.taken!=ex_br_taken_i or head.pc!=ex_br_pc_i.
//    Same cycle as upd_valid_o. Then state=FLUSH on the following edge.
//  Latency: ex_br_valid_i -> upd_valid_o/mispredict_o = 1 cycle. Push -> poppable next cycle.
//  Simultaneous push+pop (not full): both take effect, count unchanged.
//  Push in the same cycle mispredict_o is high is blocked, so nothing younger survives the flush.
//  Pointers: log2(QDepth) bits, wrap mod QDepth; count is log2(QDepth)+1 bits, 0..QDepth.
//  upd_valid_o=0 in any cycle with no sweep and no pop; data outputs then hold their last values.
//  rst_ni asserted mid-sweep or mid-run: restart INIT from ptr 0 and clear the queue.
// TESTING
//  1. Reset release, CTableSize=256 -> upd_init_o writes 0..255 on 256 cycles, then init_busy_o=0, pred_ready_o=1.
//  2. Push {pc=0x100,idx=0x80,taken=1}; resolve pc=0x100 taken=1 -> next cycle upd_valid_o=1, idx=0x80, taken=1, mispredict_o=0.
//  3. Push 3 entries, resolve the first with taken mismatch -> mispredict_o pulse, FLUSH 1 cycle, count=0, pred_ready_o=0 for 2 cycles.
//  4. Fill QDepth=4 -> pred_ready_o=0; push+pop in the same cycle -> push dropped, count=3 after.
//  5. ex_br_valid_i with queue empty -> orphan_o=1, upd_valid_o=0; during INIT -> neither.
//  6. Assert rst_ni at sweep ptr=100 -> outputs reset immediately; after release the sweep restarts at index 0.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
//   Update/recovery controller for the gshare predictor.
//   After reset it sweeps the counter table, writing the init value to
//   every entry in turn. Then it keeps one queue entry per in-flight
//   predicted branch, matches each EX resolution against the oldest entry,
//   and issues one registered counter-table update per resolved branch.
//   A direction or PC mismatch at the head raises mispredict_o. The
//   controller then spends one FLUSH cycle discarding the younger entries.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   pred_valid_i/ready_o     prediction push handshake (pc, index, taken)
//   ex_br_valid_i, pc, taken branch resolution from EX
//   upd_valid/index/init/taken_o   registered counter-table write port
//   mispredict_o, orphan_o   1-cycle status pulses
//   init_busy_o              init sweep in progress
module bp_update_ctrl #(
    parameter int CTableSize = 256,
    parameter int QDepth     = 4,
    parameter int CounterLen = 2,
    localparam int IdxW      = $clog2(CTableSize)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pred_valid_i,
    output logic            pred_ready_o,
    input  logic [31:0]     pred_pc_i,
    input  logic [IdxW-1:0] pred_index_i,
    input  logic            pred_taken_i,
    input  logic            ex_br_valid_i,
    input  logic [31:0]     ex_br_pc_i,
    input  logic            ex_br_taken_i,
    output logic            upd_valid_o,
    output logic [IdxW-1:0] upd_index_o,
    output logic            upd_init_o,
    output logic            upd_taken_o,
    output logic            mispredict_o,
    output logic            orphan_o,
    output logic            init_busy_o
);

    localparam int PtrW = $clog2(QDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] QDepthC  = CntW'(QDepth);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(CTableSize - 1);

    // The counter width only matters to the table itself (init value '0);
    // it is checked here so a bad configuration fails at elaboration.
    if (CounterLen < 1 || QDepth < 2 || (QDepth & (QDepth - 1)) != 0) begin : g_bad_param
        $error("bp_update_ctrl: illegal CounterLen/QDepth");
    end

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_e;

    typedef struct packed {
        logic [31:0]     pc;
        logic [IdxW-1:0] idx;
        logic            taken;
    } q_entry_t;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q;
    q_entry_t        q_mem [QDepth];
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] cnt_q;

    logic     push, pop, clear, orphan_d, mismatch;
    q_entry_t head;

    assign head     = q_mem[rd_q];
    assign mismatch = (head.taken != ex_br_taken_i) || (head.pc != ex_br_pc_i);

    // mispredict_o blocks pushes. A fetch on the wrong path cannot slip
    // into the queue in the cycle before the flush clears it.
    assign pred_ready_o = (state_q == S_RUN) && (cnt_q < QDepthC) && !mispredict_o;
    assign push         = pred_valid_i && pred_ready_o;
    assign init_busy_o  = (state_q == S_INIT);

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        clear    = 1'b0;
        orphan_d = 1'b0;
        case (state_q)
            S_INIT: begin
                if (ptr_q == LastIdx) state_d = S_RUN;
            end
            S_RUN: begin
                if (mispredict_o) begin
                    state_d = S_FLUSH;
                    clear   = 1'b1;
                end
                if (ex_br_valid_i) begin
                    if (cnt_q == '0) orphan_d = 1'b1;
                    else             pop      = 1'b1;
                end
            end
            S_FLUSH: begin
                state_d  = S_RUN;
                orphan_d = ex_br_valid_i;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // Counter-table write port and status pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            upd_valid_o  <= 1'b0;
            upd_index_o  <= '0;
            upd_init_o   <= 1'b0;
            upd_taken_o  <= 1'b0;
            mispredict_o <= 1'b0;
            orphan_o     <= 1'b0;
        end else begin
            orphan_o     <= orphan_d;
            mispredict_o <= pop && mismatch;
            if (state_q == S_INIT) begin
                ptr_q       <= ptr_q + 1'b1;
                upd_valid_o <= 1'b1;
                upd_init_o  <= 1'b1;
                upd_index_o <= ptr_q;
            end else begin
                // Data outputs keep their last values when no update is issued.
                upd_valid_o <= pop;
                if (pop) begin
                    upd_init_o  <= 1'b0;
                    upd_index_o <= head.idx;
                    upd_taken_o <= ex_br_taken_i;
                end
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            rd_q  <= wr_q;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + PtrW'(pop);
            wr_q  <= wr_q + PtrW'(push);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Entry storage needs no reset: the pointers and count decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) q_mem[wr_q] <= '{pc: pred_pc_i, idx: pred_index_i, taken: pred_taken_i};
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic [7:0]  pred_index_i;
    logic        pred_taken_i;
    logic        ex_br_valid_i;
    logic [31:0] ex_br_pc_i;
    logic        ex_br_taken_i;
    logic        upd_valid_o;
    logic [7:0]  upd_index_o;
    logic        upd_init_o;
    logic        upd_taken_o;
    logic        mispredict_o;
    logic        orphan_o;
    logic        init_busy_o;

    int errors = 0;
    int checks = 0;

    bp_update_ctrl #(.CTableSize(256), .QDepth(4), .CounterLen(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pred_valid_i (pred_valid_i),
        .pred_ready_o (pred_ready_o),
        .pred_pc_i    (pred_pc_i),
        .pred_index_i (pred_index_i),
        .pred_taken_i (pred_taken_i),
        .ex_br_valid_i(ex_br_valid_i),
        .ex_br_pc_i   (ex_br_pc_i),
        .ex_br_taken_i(ex_br_taken_i),
        .upd_valid_o  (upd_valid_o),
        .upd_index_o  (upd_index_o),
        .upd_init_o   (upd_init_o),
        .upd_taken_o  (upd_taken_o),
        .mispredict_o (mispredict_o),
        .orphan_o     (orphan_o),
        .init_busy_o  (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [7:0] idx, input logic tk);
        pred_valid_i = 1'b1;
        pred_pc_i    = pc;
        pred_index_i = idx;
        pred_taken_i = tk;
        step();
        pred_valid_i = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk);
        ex_br_valid_i = 1'b1;
        ex_br_pc_i    = pc;
        ex_br_taken_i = tk;
        step();
        ex_br_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        pred_valid_i  = 1'b0;
        pred_pc_i     = '0;
        pred_index_i  = '0;
        pred_taken_i  = 1'b0;
        ex_br_valid_i = 1'b0;
        ex_br_pc_i    = '0;
        ex_br_taken_i = 1'b0;
        step();
        step();

        // reset state
        chk("rst_busy",   init_busy_o,  1);
        chk("rst_valid",  upd_valid_o,  0);
        chk("rst_ready",  pred_ready_o, 0);
        chk("rst_mispr",  mispredict_o, 0);
        chk("rst_orphan", orphan_o,     0);
        chk("rst_index",  upd_index_o,  0);

        // full sweep; EX resolutions are ignored throughout INIT
        rst_ni        = 1'b1;
        ex_br_valid_i = 1'b1;
        ex_br_pc_i    = 32'h40;
        for (int i = 0; i < 256; i++) begin
            step();
            chk("sweep_valid",  upd_valid_o, 1);
            chk("sweep_init",   upd_init_o,  1);
            chk("sweep_idx",    upd_index_o, i);
            chk("sweep_orphan", orphan_o,    0);
            chk("sweep_busy",   init_busy_o, (i == 255) ? 0 : 1);
        end
        ex_br_valid_i = 1'b0;
        chk("run_ready", pred_ready_o, 1);
        step();
        chk("run_idle_valid", upd_valid_o, 0);

        // single correct prediction
        push(32'h100, 8'h80, 1'b1);
        resolve(32'h100, 1'b1);
        chk("hit_valid", upd_valid_o,  1);
        chk("hit_init",  upd_init_o,   0);
        chk("hit_idx",   upd_index_o,  8'h80);
        chk("hit_taken", upd_taken_o,  1);
        chk("hit_mispr", mispredict_o, 0);
        step();
        chk("hold_valid", upd_valid_o, 0);
        chk("hold_idx",   upd_index_o, 8'h80);

        // resolution with an empty queue
        resolve(32'h200, 1'b0);
        chk("orph_pulse", orphan_o,    1);
        chk("orph_valid", upd_valid_o, 0);
        step();
        chk("orph_clear", orphan_o,    0);

        // mispredict on the oldest of three entries
        push(32'h300, 8'h10, 1'b1);
        push(32'h304, 8'h11, 1'b0);
        push(32'h308, 8'h12, 1'b1);
        resolve(32'h300, 1'b0);
        chk("mp_pulse", mispredict_o, 1);
        chk("mp_valid", upd_valid_o,  1);
        chk("mp_idx",   upd_index_o,  8'h10);
        chk("mp_taken", upd_taken_o,  0);
        chk("mp_ready", pred_ready_o, 0);
        // this push attempt is blocked here and in FLUSH
        pred_valid_i = 1'b1;
        pred_pc_i    = 32'h30c;
        pred_index_i = 8'h13;
        pred_taken_i = 1'b1;
        step();
        chk("fl_mispr", mispredict_o, 0);
        chk("fl_ready", pred_ready_o, 0);
        chk("fl_valid", upd_valid_o,  0);
        ex_br_valid_i = 1'b1;
        ex_br_pc_i    = 32'h999;
        step();
        pred_valid_i  = 1'b0;
        ex_br_valid_i = 1'b0;
        chk("fl_orphan", orphan_o,     1);
        chk("fl_upd",    upd_valid_o,  0);
        chk("fl_back",   pred_ready_o, 1);
        // younger entries are gone: next resolve finds the queue empty
        resolve(32'h304, 1'b0);
        chk("fl_empty_orphan", orphan_o,    1);
        chk("fl_empty_valid",  upd_valid_o, 0);

        // fill to QDepth, then push+pop at full
        push(32'h400, 8'h20, 1'b1);
        push(32'h404, 8'h21, 1'b1);
        push(32'h408, 8'h22, 1'b0);
        push(32'h40c, 8'h23, 1'b0);
        chk("full_ready", pred_ready_o, 0);
        pred_valid_i  = 1'b1;
        pred_pc_i     = 32'h410;
        pred_index_i  = 8'h24;
        pred_taken_i  = 1'b1;
        resolve(32'h400, 1'b1);
        pred_valid_i  = 1'b0;
        chk("full_pop_idx",   upd_index_o,  8'h20);
        chk("full_pop_mispr", mispredict_o, 0);
        chk("full_ready3",    pred_ready_o, 1);
        resolve(32'h404, 1'b1);
        chk("drain_b", upd_index_o, 8'h21);
        resolve(32'h408, 1'b0);
        chk("drain_c", upd_index_o, 8'h22);
        chk("drain_c_taken", upd_taken_o, 0);
        resolve(32'h40c, 1'b0);
        chk("drain_d", upd_index_o, 8'h23);
        chk("drain_d_mispr", mispredict_o, 0);
        resolve(32'h410, 1'b1);
        chk("dropped_orphan", orphan_o,    1);
        chk("dropped_valid",  upd_valid_o, 0);

        // reset in the middle of the sweep, with a live queue entry
        push(32'h500, 8'h30, 1'b1);
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk("sweep2_idx", upd_index_o, k);
        end
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", upd_valid_o, 0);
        chk("mid_rst_busy",  init_busy_o, 1);
        chk("mid_rst_idx",   upd_index_o, 0);
        chk("mid_rst_init",  upd_init_o,  0);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            chk("sweep3_idx", upd_index_o, k);
            chk("sweep3_valid", upd_valid_o, 1);
        end
        chk("sweep3_busy",  init_busy_o,  0);
        chk("sweep3_ready", pred_ready_o, 1);
        resolve(32'h500, 1'b1);
        chk("rst_q_orphan", orphan_o,    1);
        chk("rst_q_valid",  upd_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
